// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants, FSM state and packet types for the 4-port switch
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int PTR_W     = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        TRANSMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    source;
        logic [NUM_PORTS-1:0] target;
        logic [DATA_W-1:0]    data;
    } packet_t;

endpackage

// File: rtl/port_if.sv
// rtl/port_if.sv - per-port bus bundle between an agent and the switch
interface port_if (
    input logic clk,
    input logic rst_n
);
    import switch_pkg::*;

    logic                 valid_in;
    logic [ADDR_W-1:0]    source_in;
    logic [NUM_PORTS-1:0] target_in;
    logic [DATA_W-1:0]    data_in;
    logic                 ready;
    logic                 valid_out;
    logic [ADDR_W-1:0]    source_out;
    logic [NUM_PORTS-1:0] target_out;
    logic [DATA_W-1:0]    data_out;

    modport dut (
        input  clk, rst_n, valid_in, source_in, target_in, data_in,
        output ready, valid_out, source_out, target_out, data_out
    );

    modport tb (
        input  clk, rst_n, ready, valid_out, source_out, target_out, data_out,
        output valid_in, source_in, target_in, data_in
    );

endinterface

// File: rtl/switch_port.sv
// rtl/switch_port.sv - per-port ingress FSM, packet buffer and pending mask (SWITCH_LOOPBACK_EN keeps own target bit)
module switch_port
    import switch_pkg::*;
#(
    parameter int PORT_ID = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [ADDR_W-1:0]    source_in,
    input  logic [NUM_PORTS-1:0] target_in,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] gnt,
    output logic                 ready,
    output logic [NUM_PORTS-1:0] req,
    output packet_t              pkt
);

    localparam logic [NUM_PORTS-1:0] OWN_BIT = NUM_PORTS'(1 << PORT_ID);

    state_t               state, state_n;
    packet_t              pkt_q, pkt_n;
    logic [NUM_PORTS-1:0] pending, pending_n;
    logic [NUM_PORTS-1:0] keep_mask;

`ifdef SWITCH_LOOPBACK_EN
    assign keep_mask = '1;
`else
    assign keep_mask = ~OWN_BIT;
`endif

    assign pkt = pkt_q;

    // State, captured packet and outstanding-output mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pkt_q   <= '0;
            pending <= '0;
        end else begin
            state   <= state_n;
            pkt_q   <= pkt_n;
            pending <= pending_n;
        end
    end

    // Next state: capture in IDLE, one settle cycle, then request until every target is served
    always_comb begin
        state_n   = state;
        pkt_n     = pkt_q;
        pending_n = pending;
        ready     = 1'b0;
        req       = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid_in) begin
                    pkt_n     = '{source: source_in, target: target_in, data: data_in};
                    pending_n = target_in & keep_mask;
                    state_n   = (pending_n != '0) ? RECEIVE : IDLE;
                end
            end
            RECEIVE: begin
                state_n = TRANSMIT;
            end
            TRANSMIT: begin
                req       = pending;
                pending_n = pending & ~gnt;
                if (pending_n == '0) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n   = IDLE;
                pending_n = '0;
            end
        endcase
    end

endmodule

// File: rtl/switch_4port.sv
// rtl/switch_4port.sv - four-port multicast switch: ingress FSMs, round-robin output arbiters, registered outputs
module switch_4port
    import switch_pkg::*;
(
    input logic clk,
    input logic rst_n,
    port_if.dut port0,
    port_if.dut port1,
    port_if.dut port2,
    port_if.dut port3
);

    logic [NUM_PORTS-1:0] in_valid;
    logic [NUM_PORTS-1:0] in_ready;
    logic [ADDR_W-1:0]    in_source [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_target [NUM_PORTS];
    logic [DATA_W-1:0]    in_data   [NUM_PORTS];
    logic [NUM_PORTS-1:0] req       [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt       [NUM_PORTS];
    packet_t              port_pkt  [NUM_PORTS];
    logic [PTR_W-1:0]     ptr       [NUM_PORTS];
    logic [PTR_W-1:0]     win       [NUM_PORTS];
    logic [PTR_W-1:0]     cand;
    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] out_valid;
    packet_t              out_pkt   [NUM_PORTS];

    assign in_valid[0] = port0.valid_in;  assign in_source[0] = port0.source_in;
    assign in_valid[1] = port1.valid_in;  assign in_source[1] = port1.source_in;
    assign in_valid[2] = port2.valid_in;  assign in_source[2] = port2.source_in;
    assign in_valid[3] = port3.valid_in;  assign in_source[3] = port3.source_in;
    assign in_target[0] = port0.target_in; assign in_data[0] = port0.data_in;
    assign in_target[1] = port1.target_in; assign in_data[1] = port1.data_in;
    assign in_target[2] = port2.target_in; assign in_data[2] = port2.data_in;
    assign in_target[3] = port3.target_in; assign in_data[3] = port3.data_in;

    assign port0.ready = in_ready[0];
    assign port1.ready = in_ready[1];
    assign port2.ready = in_ready[2];
    assign port3.ready = in_ready[3];

    assign port0.valid_out = out_valid[0];
    assign port1.valid_out = out_valid[1];
    assign port2.valid_out = out_valid[2];
    assign port3.valid_out = out_valid[3];
    assign port0.source_out = out_pkt[0].source; assign port0.target_out = out_pkt[0].target;
    assign port1.source_out = out_pkt[1].source; assign port1.target_out = out_pkt[1].target;
    assign port2.source_out = out_pkt[2].source; assign port2.target_out = out_pkt[2].target;
    assign port3.source_out = out_pkt[3].source; assign port3.target_out = out_pkt[3].target;
    assign port0.data_out = out_pkt[0].data;
    assign port1.data_out = out_pkt[1].data;
    assign port2.data_out = out_pkt[2].data;
    assign port3.data_out = out_pkt[3].data;

    switch_port #(.PORT_ID(0)) P0 (
        .clk(clk), .rst_n(rst_n), .valid_in(in_valid[0]), .source_in(in_source[0]),
        .target_in(in_target[0]), .data_in(in_data[0]), .gnt(gnt[0]),
        .ready(in_ready[0]), .req(req[0]), .pkt(port_pkt[0])
    );
    switch_port #(.PORT_ID(1)) P1 (
        .clk(clk), .rst_n(rst_n), .valid_in(in_valid[1]), .source_in(in_source[1]),
        .target_in(in_target[1]), .data_in(in_data[1]), .gnt(gnt[1]),
        .ready(in_ready[1]), .req(req[1]), .pkt(port_pkt[1])
    );
    switch_port #(.PORT_ID(2)) P2 (
        .clk(clk), .rst_n(rst_n), .valid_in(in_valid[2]), .source_in(in_source[2]),
        .target_in(in_target[2]), .data_in(in_data[2]), .gnt(gnt[2]),
        .ready(in_ready[2]), .req(req[2]), .pkt(port_pkt[2])
    );
    switch_port #(.PORT_ID(3)) P3 (
        .clk(clk), .rst_n(rst_n), .valid_in(in_valid[3]), .source_in(in_source[3]),
        .target_in(in_target[3]), .data_in(in_data[3]), .gnt(gnt[3]),
        .ready(in_ready[3]), .req(req[3]), .pkt(port_pkt[3])
    );

    // Per-output round-robin: first requester at or after the pointer wins; grants may fan out to one input
    always_comb begin
        hit  = '0;
        cand = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt[i] = '0;
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            win[j] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand = ptr[j] + PTR_W'(k);
                if (!hit[j] && req[cand][j]) begin
                    hit[j] = 1'b1;
                    win[j] = cand;
                end
            end
            if (hit[j]) begin
                gnt[win[j]][j] = 1'b1;
            end
        end
    end

    // Arbiter pointers advance past the grantee; granted packet is registered onto the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                ptr[j]     <= '0;
                out_pkt[j] <= '0;
            end
        end else begin
            out_valid <= hit;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (hit[j]) begin
                    ptr[j]     <= win[j] + PTR_W'(1);
                    out_pkt[j] <= port_pkt[win[j]];
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_4port.sv
// tb/tb_switch_4port.sv - directed self-checking bench for switch_4port
module tb_switch_4port;
    import switch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    port_if pif [NUM_PORTS] (.clk(clk), .rst_n(rst_n));

    logic [NUM_PORTS-1:0] vin, vout, rdy;
    logic [ADDR_W-1:0]    sin  [NUM_PORTS];
    logic [ADDR_W-1:0]    sout [NUM_PORTS];
    logic [NUM_PORTS-1:0] tin  [NUM_PORTS];
    logic [NUM_PORTS-1:0] tout [NUM_PORTS];
    logic [DATA_W-1:0]    din  [NUM_PORTS];
    logic [DATA_W-1:0]    dout [NUM_PORTS];
    state_t               st   [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_conn
        assign pif[g].valid_in  = vin[g];
        assign pif[g].source_in = sin[g];
        assign pif[g].target_in = tin[g];
        assign pif[g].data_in   = din[g];
        assign vout[g] = pif[g].valid_out;
        assign rdy[g]  = pif[g].ready;
        assign sout[g] = pif[g].source_out;
        assign tout[g] = pif[g].target_out;
        assign dout[g] = pif[g].data_out;
    end

    assign st[0] = dut.P0.state;
    assign st[1] = dut.P1.state;
    assign st[2] = dut.P2.state;
    assign st[3] = dut.P3.state;

    switch_4port dut (
        .clk(clk), .rst_n(rst_n),
        .port0(pif[0]), .port1(pif[1]), .port2(pif[2]), .port3(pif[3])
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic                 vh [0:15][0:3];
    logic [ADDR_W-1:0]    sh [0:15][0:3];
    logic [NUM_PORTS-1:0] th [0:15][0:3];
    logic [DATA_W-1:0]    dh [0:15][0:3];
    logic                 rh [0:15][0:3];

    typedef struct {
        int                   port;
        logic [ADDR_W-1:0]    src;
        logic [NUM_PORTS-1:0] tgt;
        logic [DATA_W-1:0]    data;
        logic [NUM_PORTS-1:0] exp_out;
    } vec_t;

`ifdef SWITCH_LOOPBACK_EN
    localparam logic [NUM_PORTS-1:0] SELF_OUT = 4'b1000;
`else
    localparam logic [NUM_PORTS-1:0] SELF_OUT = 4'b0000;
`endif

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int p, input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
        @(negedge clk);
        vin[p] = 1'b1; sin[p] = s; tin[p] = t; din[p] = d;
        @(negedge clk);
        vin[p] = 1'b0;
    endtask

    task automatic monitor(input int n);
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < NUM_PORTS; p++) vh[c][p] = 1'b0;
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            for (int p = 0; p < NUM_PORTS; p++) begin
                vh[c][p] = vout[p]; sh[c][p] = sout[p]; th[c][p] = tout[p];
                dh[c][p] = dout[p]; rh[c][p] = rdy[p];
            end
        end
    endtask

    function automatic int pulses(input int p);
        int cnt = 0;
        for (int c = 0; c < 16; c++) if (vh[c][p] === 1'b1) cnt++;
        return cnt;
    endfunction

    function automatic int first_cyc(input int p);
        for (int c = 0; c < 16; c++) if (vh[c][p] === 1'b1) return c;
        return 0;
    endfunction

    initial begin
        vin = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sin[p] = '0; tin[p] = '0; din[p] = '0;
        end
        vecs[0] = '{port: 0, src: 4'b0001, tgt: 4'b0100, data: 8'hA5, exp_out: 4'b0100};
        vecs[1] = '{port: 1, src: 4'b0010, tgt: 4'b1101, data: 8'h3C, exp_out: 4'b1101};
        vecs[2] = '{port: 3, src: 4'b0011, tgt: 4'b1000, data: 8'h77, exp_out: SELF_OUT};
        vecs[3] = '{port: 3, src: 4'b0011, tgt: 4'b0000, data: 8'h11, exp_out: 4'b0000};
        vecs[4] = '{port: 2, src: 4'b0100, tgt: 4'b0011, data: 8'hC3, exp_out: 4'b0011};

        // reset state
        repeat (3) @(negedge clk);
        for (int p = 0; p < NUM_PORTS; p++) begin
            check($sformatf("reset_valid_out[%0d]", p), 32'(vout[p]), 32'd0);
            check($sformatf("reset_ready[%0d]", p), 32'(rdy[p]), 32'd1);
            check($sformatf("reset_state[%0d]", p), 32'(st[p]), 32'(IDLE));
            check($sformatf("reset_data_out[%0d]", p), 32'(dout[p]), 32'd0);
        end
        rst_n = 1'b1;

        // single-packet vectors
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].port, vecs[v].src, vecs[v].tgt, vecs[v].data);
            monitor(6);
            for (int j = 0; j < NUM_PORTS; j++) begin
                check($sformatf("v%0d_pulses[%0d]", v, j), 32'(pulses(j)), 32'(vecs[v].exp_out[j]));
                if (vecs[v].exp_out[j]) begin
                    check($sformatf("v%0d_latency[%0d]", v, j), 32'(first_cyc(j)), 32'd2);
                    check($sformatf("v%0d_source[%0d]", v, j), 32'(sh[2][j]), 32'(vecs[v].src));
                    check($sformatf("v%0d_target[%0d]", v, j), 32'(th[2][j]), 32'(vecs[v].tgt));
                    check($sformatf("v%0d_data[%0d]", v, j), 32'(dh[2][j]), 32'(vecs[v].data));
                end
            end
            check($sformatf("v%0d_ready_busy", v), 32'(rh[1][vecs[v].port]), 32'(vecs[v].exp_out == 4'b0000));
            check($sformatf("v%0d_state_idle", v), 32'(st[vecs[v].port]), 32'(IDLE));
            check($sformatf("v%0d_ready_after", v), 32'(rdy[vecs[v].port]), 32'd1);
        end

        // contention on output 2 from inputs 0, 1, 3 with a fresh pointer
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vin[0] = 1'b1; sin[0] = 4'd0; tin[0] = 4'b0100; din[0] = 8'h10;
        vin[1] = 1'b1; sin[1] = 4'd1; tin[1] = 4'b0100; din[1] = 8'h11;
        vin[3] = 1'b1; sin[3] = 4'd3; tin[3] = 4'b0100; din[3] = 8'h13;
        @(negedge clk);
        vin = '0;
        monitor(8);
        check("cont_pulses", 32'(pulses(2)), 32'd3);
        check("cont_c2_data", 32'(vh[2][2] ? dh[2][2] : 8'h00), 32'h10);
        check("cont_c3_data", 32'(vh[3][2] ? dh[3][2] : 8'h00), 32'h11);
        check("cont_c4_data", 32'(vh[4][2] ? dh[4][2] : 8'h00), 32'h13);
        check("cont_c4_source", 32'(sh[4][2]), 32'd3);
        check("cont_others_silent", 32'(pulses(0) + pulses(1) + pulses(3)), 32'd0);

        // pointer wrapped to 0 after granting input 3: input 0 must win over input 3
        @(negedge clk);
        vin[3] = 1'b1; sin[3] = 4'd3; tin[3] = 4'b0100; din[3] = 8'h23;
        vin[0] = 1'b1; sin[0] = 4'd0; tin[0] = 4'b0100; din[0] = 8'h20;
        @(negedge clk);
        vin = '0;
        monitor(6);
        check("wrap_pulses", 32'(pulses(2)), 32'd2);
        check("wrap_first", 32'(vh[2][2] ? dh[2][2] : 8'h00), 32'h20);
        check("wrap_second", 32'(vh[3][2] ? dh[3][2] : 8'h00), 32'h23);

        // reset while port 0 is in TRANSMIT
        send(0, 4'd5, 4'b0010, 8'h99);
        @(posedge clk);
        #1;
        check("mid_state_transmit", 32'(st[0]), 32'(TRANSMIT));
        rst_n = 1'b0;
        #1;
        check("mid_valid_out", 32'(vout), 32'd0);
        check("mid_data_out_cleared", 32'(dout[2]), 32'd0);
        check("mid_state_idle", 32'(st[0]), 32'(IDLE));
        check("mid_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        monitor(6);
        check("mid_never_emitted", 32'(pulses(0) + pulses(1) + pulses(2) + pulses(3)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
